// File: rtl/seg7_scan_capture.sv
// Rebuilds BCD digits from a scanned 7-segment bus and emits whole frames on valid/ready.
// Latency: digit accepted STABLE_CYCLES-1 edges after its first sample; frame out 1 edge after completion.
// Backpressure: held frame stays frozen while !frame_ready_i; a frame completing meanwhile is dropped with overrun_o.
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_i,
    input  logic [NUM_DIGITS-1:0]     dig_en_i,
    input  logic                      frame_ready_i,
    output logic                      frame_valid_o,
    output logic [4*NUM_DIGITS-1:0]   bcd_out_o,
    output logic [NUM_DIGITS-1:0]     blank_mask_o,
    output logic [NUM_DIGITS-1:0]     invalid_mask_o,
    output logic                      overrun_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0] dig_en;
        logic [6:0]            seg;
    } samp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    // Returns {blank, invalid, bcd}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        r = {2'b01, 4'hF};
        case (s)
            7'h7E: r = {2'b00, 4'd0};
            7'h30: r = {2'b00, 4'd1};
            7'h6D: r = {2'b00, 4'd2};
            7'h79: r = {2'b00, 4'd3};
            7'h33: r = {2'b00, 4'd4};
            7'h5B: r = {2'b00, 4'd5};
            7'h5F: r = {2'b00, 4'd6};
            7'h70: r = {2'b00, 4'd7};
            7'h7F: r = {2'b00, 4'd8};
            7'h7B: r = {2'b00, 4'd9};
            7'h00: r = {2'b10, 4'd0};
            default: r = {2'b01, 4'hF};
        endcase
        return r;
    endfunction

    samp_t                   in_q, samp_d;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   collected_q, collected_d, coll_acc;
    logic [4*NUM_DIGITS-1:0] sh_bcd_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_inv_q;
    logic                    complete_q, complete_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   blank_q, inv_q;
    logic                    overrun_q, overrun_d;
    logic                    accept, load, same, onehot;
    logic [5:0]              dec;

    assign samp_d = '{dig_en: dig_en_i, seg: seg_i};
    assign onehot = $onehot(dig_en_i);
    assign same   = (samp_d == in_q);
    assign dec    = decode(seg_i);

    // Dwell tracking compares the sample being captured with the one already in in_q,
    // so the accept (the transient ACCEPT step) lands on the edge the count hits STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!onehot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!(state_q == ST_HOLD && same)) begin
            if (state_q == ST_IDLE || !same)
                cnt_d = CW'(1);
            else if (cnt_q < CW'(STABLE_CYCLES))
                cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(STABLE_CYCLES)) begin
                accept  = 1'b1;
                state_d = ST_HOLD;
            end else begin
                state_d = ST_SETTLE;
            end
        end
    end

    always_comb begin
        coll_acc    = collected_q | (accept ? dig_en_i : '0);
        complete_d  = accept && (&coll_acc);
        collected_d = complete_d ? '0 : coll_acc;
    end

    always_comb begin
        valid_d   = valid_q;
        overrun_d = 1'b0;
        load      = 1'b0;
        if (complete_q) begin
            if (valid_q && !frame_ready_i)
                overrun_d = 1'b1;
            else
                load = 1'b1;
        end else if (valid_q && frame_ready_i) begin
            valid_d = 1'b0;
        end
        if (load)
            valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            collected_q <= '0;
            complete_q  <= 1'b0;
            sh_bcd_q    <= '0;
            sh_blank_q  <= '0;
            sh_inv_q    <= '0;
            valid_q     <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= '0;
            inv_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            in_q        <= samp_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            collected_q <= collected_d;
            complete_q  <= complete_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && dig_en_i[i]) begin
                    sh_bcd_q[4*i +: 4] <= dec[3:0];
                    sh_blank_q[i]      <= dec[5];
                    sh_inv_q[i]        <= dec[4];
                end
            end
            if (load) begin
                bcd_q   <= sh_bcd_q;
                blank_q <= sh_blank_q;
                inv_q   <= sh_inv_q;
            end
        end
    end

    assign frame_valid_o  = valid_q;
    assign bcd_out_o      = bcd_q;
    assign blank_mask_o   = blank_q;
    assign invalid_mask_o = inv_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: frame vector table, corner sequences, random scan against a run-length model.
module tb_seg7_scan_capture;
    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg = '0;
    logic [N-1:0]  dig_en = '0;
    logic          frame_ready = 1'b1;
    logic          frame_valid, overrun;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]  blank_mask, invalid_mask;

    seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_i(seg), .dig_en_i(dig_en),
        .frame_ready_i(frame_ready), .frame_valid_o(frame_valid),
        .bcd_out_o(bcd_out), .blank_mask_o(blank_mask),
        .invalid_mask_o(invalid_mask), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] pat_tab [11] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                 7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h00};
    logic [3:0] val_tab [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};

    // Reference model: a digit is taken when its one-hot sample has repeated exactly S times.
    logic [N+6:0]   m_last;
    int             m_run;
    logic [3:0]     m_sh_bcd [N];
    logic [N-1:0]   m_sh_bl, m_sh_inv, m_coll;
    bit             m_pend;
    logic           m_valid, m_ov;
    logic [4*N-1:0] m_bcd;
    logic [N-1:0]   m_bl, m_inv;

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] v,
                              output logic bl, output logic inv);
        v = 4'hF; bl = 1'b0; inv = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (pat_tab[k] == s) begin
                v = val_tab[k]; bl = (k == 10); inv = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        logic [N+6:0] s;
        bit           oh;
        int           idx;
        logic [3:0]   v;
        logic         bl, iv;
        if (!rst_n) begin
            m_last = '0; m_run = 0; m_coll = '0; m_pend = 0;
            m_valid = 0; m_ov = 0; m_bcd = '0; m_bl = '0; m_inv = '0;
            m_sh_bl = '0; m_sh_inv = '0;
            for (int i = 0; i < N; i++) m_sh_bcd[i] = '0;
        end else begin
            s  = {dig_en, seg};
            oh = ($countones(dig_en) == 1);
            m_ov = 0;
            if (m_pend) begin
                if (m_valid && !frame_ready) m_ov = 1;
                else begin
                    m_valid = 1;
                    for (int i = 0; i < N; i++) m_bcd[4*i +: 4] = m_sh_bcd[i];
                    m_bl = m_sh_bl; m_inv = m_sh_inv;
                end
            end else if (m_valid && frame_ready) m_valid = 0;
            m_pend = 0;
            if (oh && s == m_last) m_run++;
            else m_run = oh ? 1 : 0;
            m_last = s;
            if (m_run == S) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (dig_en[i]) idx = i;
                ref_decode(seg, v, bl, iv);
                m_sh_bcd[idx] = v; m_sh_bl[idx] = bl; m_sh_inv[idx] = iv;
                m_coll[idx] = 1'b1;
                if (&m_coll) begin m_pend = 1; m_coll = '0; end
            end
        end
    end

    // Handshake accounting at the consuming edge.
    int             frames_seen = 0;
    logic [4*N-1:0] cap_bcd = '0;
    logic [N-1:0]   cap_bl = '0, cap_inv = '0;
    always @(posedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            frames_seen++;
            cap_bcd = bcd_out; cap_bl = blank_mask; cap_inv = invalid_mask;
        end
    end

    int ov_seen = 0;
    always @(negedge clk) begin
        if (overrun) ov_seen++;
        tests++;
        if (frame_valid !== m_valid || bcd_out !== m_bcd || blank_mask !== m_bl ||
            invalid_mask !== m_inv || overrun !== m_ov) begin
            fails++;
            $display("FAIL model_cmp t=%0t dut v=%b bcd=%h bl=%b inv=%b ov=%b / expected v=%b bcd=%h bl=%b inv=%b ov=%b",
                     $time, frame_valid, bcd_out, blank_mask, invalid_mask, overrun,
                     m_valid, m_bcd, m_bl, m_inv, m_ov);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        dig_en = '0;
        dig_en[d] = 1'b1;
        seg = p;
        step(n);
    endtask

    task automatic show_frame(input logic [7*N-1:0] pk);
        for (int i = 0; i < N; i++) show(i, pk[7*i +: 7], 8);
    endtask

    typedef struct {
        logic [7*N-1:0] pats;
        logic [4*N-1:0] bcd;
        logic [N-1:0]   bl;
        logic [N-1:0]   inv;
    } vec_t;
    vec_t vt[$];

    initial begin
        vec_t       v;
        int         f0, o0;
        logic [3:0] r;

        v = '{{7'h33, 7'h79, 7'h6D, 7'h30}, 16'h4321, 4'b0000, 4'b0000}; vt.push_back(v);
        v = '{{7'h7C, 7'h00, 7'h6D, 7'h30}, 16'hF021, 4'b0100, 4'b1000}; vt.push_back(v);
        v = '{{7'h00, 7'h47, 7'h7F, 7'h01}, 16'h0F8F, 4'b1000, 4'b0101}; vt.push_back(v);
        for (int j = 0; j < 11; j++) begin
            v.bl = '0; v.inv = '0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (j + i) % 11;
                v.pats[7*i +: 7] = pat_tab[k];
                v.bcd[4*i +: 4]  = val_tab[k];
                v.bl[i]          = (k == 10);
            end
            vt.push_back(v);
        end

        step(3);
        chk("reset_valid", 32'(frame_valid), 0);
        chk("reset_bcd", 32'(bcd_out), 0);
        chk("reset_masks", 32'({blank_mask, invalid_mask, overrun}), 0);
        rst_n = 1'b1;
        step(2);

        foreach (vt[t]) begin
            f0 = frames_seen;
            show_frame(vt[t].pats);
            chk($sformatf("vec%0d_frames", t), 32'(frames_seen - f0), 1);
            chk($sformatf("vec%0d_bcd", t), 32'(cap_bcd), 32'(vt[t].bcd));
            chk($sformatf("vec%0d_blank", t), 32'(cap_bl), 32'(vt[t].bl));
            chk($sformatf("vec%0d_invalid", t), 32'(cap_inv), 32'(vt[t].inv));
        end

        // Short dwell and multi-hot enable must both be ignored.
        f0 = frames_seen;
        show(0, 7'h30, 8); show(1, 7'h5B, 2); show(1, 7'h6D, 8);
        dig_en = 4'b0011; seg = 7'h7F; step(8);
        show(2, 7'h79, 8); show(3, 7'h33, 8);
        chk("short_dwell_frames", 32'(frames_seen - f0), 1);
        chk("short_dwell_bcd", 32'(cap_bcd), 32'h4321);

        // Backpressure over two frames.
        frame_ready = 1'b0;
        f0 = frames_seen; o0 = ov_seen;
        show_frame({7'h79, 7'h6D, 7'h30, 7'h7E});
        chk("bp_valid_a", 32'(frame_valid), 1);
        chk("bp_bcd_a", 32'(bcd_out), 32'h3210);
        show_frame({7'h70, 7'h5F, 7'h5B, 7'h33});
        chk("bp_valid_b", 32'(frame_valid), 1);
        chk("bp_bcd_held", 32'(bcd_out), 32'h3210);
        chk("bp_overrun_pulses", 32'(ov_seen - o0), 1);
        frame_ready = 1'b1;
        step(1);
        chk("bp_valid_drop", 32'(frame_valid), 0);
        chk("bp_frames", 32'(frames_seen - f0), 1);
        chk("bp_consumed_bcd", 32'(cap_bcd), 32'h3210);

        // Reset mid-frame discards partial collection.
        show(0, 7'h30, 8); show(1, 7'h6D, 8); show(2, 7'h79, 8);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(frame_valid), 0);
        chk("rst_mid_bcd", 32'(bcd_out), 0);
        f0 = frames_seen;
        show(3, 7'h33, 8);
        chk("rst_partial_no_frame", 32'(frames_seen - f0), 0);
        chk("rst_partial_valid", 32'(frame_valid), 0);
        show(0, 7'h30, 8); show(1, 7'h6D, 8); show(2, 7'h79, 8);
        chk("rst_refill_frames", 32'(frames_seen - f0), 1);
        chk("rst_refill_bcd", 32'(cap_bcd), 32'h4321);

        // Random scanning with random backpressure, checked every cycle against the model.
        for (int n = 0; n < 500; n++) begin
            r = 4'($urandom_range(0, 15));
            seg = (r < 11) ? pat_tab[r] : 7'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                dig_en = '0;
                dig_en[$urandom_range(0, N-1)] = 1'b1;
            end else begin
                dig_en = N'($urandom);
            end
            frame_ready = ($urandom_range(0, 9) < 7);
            step($urandom_range(1, 7));
        end
        frame_ready = 1'b1;
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
